// File: rtl/fetch_unit_pkg.sv
// Shared fetch constants and the F/D bundle type, common to fetch, next-PC logic and CP0.
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET      = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY     = 32'h0000_4180;
  localparam logic [31:0] IM_BASE       = 32'h0000_3000;
  localparam logic [31:0] IM_TOP        = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_CODE_ADEL = 5'd4;
  localparam logic [31:0] NOP           = 32'h0000_0000;

  // Contents of one pipeline-register slot handed from F to D.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc_adel;
    logic        valid;
  } fd_bundle_t;

  localparam fd_bundle_t FD_BUBBLE = '{instr: NOP, pc: 32'h0, exc_adel: 1'b0, valid: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: address out from fetch, same-cycle read data back.
interface fetch_unit_if;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  modport master (output i_inst_addr, input i_inst_rdata);
  modport slave  (input i_inst_addr, output i_inst_rdata);
endinterface

// File: rtl/fetch_unit_fd_reg.sv
// Pipeline register slot with reset, flush-to-bubble and stall-hold.
module fetch_unit_fd_reg
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flush,
  input  logic       i_stall,
  input  fd_bundle_t i_d,
  output fd_bundle_t o_q
);

  fd_bundle_t r_q;

  // Reset and flush both load a bubble; flush beats stall.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_q <= FD_BUBBLE;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// F stage: PC register, fetch-address legality check, and the F/D register.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  F_nextPC,
  input  logic         stall,
  input  logic         exc_req,
  output logic [31:0]  F_PC,
  fetch_unit_if.master im,
  output logic [31:0]  D_instr,
  output logic [31:0]  D_PC,
  output logic         D_excAdEL,
  output logic         D_valid
);

  logic [31:0] r_pc;
  logic        w_adel;
  fd_bundle_t  w_fd_d;
  fd_bundle_t  w_fd_q;

  // PC register: exception redirect overrides stall; F_nextPC is taken verbatim.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= PC_RESET;
    end else if (exc_req) begin
      r_pc <= EXC_ENTRY;
    end else if (!stall) begin
      r_pc <= F_nextPC;
    end
  end

  assign F_PC           = r_pc;
  assign im.i_inst_addr = r_pc;

  // Fetch check: misaligned or outside the instruction window; illegal fetches become nop.
  always_comb begin
    w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_TOP);
    w_fd_d = '{instr:    w_adel ? NOP : im.i_inst_rdata,
               pc:       r_pc,
               exc_adel: w_adel,
               valid:    1'b1};
  end

  fetch_unit_fd_reg u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .i_flush (exc_req),
    .i_stall (stall),
    .i_d     (w_fd_d),
    .o_q     (w_fd_q)
  );

  assign D_instr   = w_fd_q.instr;
  assign D_PC      = w_fd_q.pc;
  assign D_excAdEL = w_fd_q.exc_adel;
  assign D_valid   = w_fd_q.valid;

endmodule
